// File: rtl/aes_pkg.sv
// aes_pkg: shared block geometry, sender state type and word-select helper for the AES input port.
package aes_pkg;
  localparam int AES_BLK_BYTES = 16;
  localparam int AES_BLK_WORDS = 4;
  localparam int AES_WORD_W    = 32;
  typedef enum logic {IDLE, SEND} aes_state_e;
  function automatic logic [AES_WORD_W-1:0] aes_word(input logic [8*AES_BLK_BYTES-1:0] blk,
                                                     input logic [1:0] idx);
    return blk[8*AES_BLK_BYTES-1 - AES_WORD_W*idx -: AES_WORD_W];
  endfunction
endpackage

// File: rtl/aes_inport_sync.sv
// aes_inport_sync: two-flop synchronizer with a configurable reset value.
module aes_inport_sync #(
  parameter int           W       = 9,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
endmodule

// File: rtl/aes_inport.sv
// aes_inport: byte-serial block receiver that bursts each 128-bit block to the AES core as four words.
// Defining AES_INPORT_SYNC_EN adds a 2-flop input synchronizer (+2 cycles latency).
module aes_inport import aes_pkg::*; #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic [AES_WORD_W-1:0] pass_data,
  output logic                  aes_en,
  output logic                  in_busy,
  output logic                  err_tout
);
  localparam int BW = 8 * AES_BLK_BYTES;
  localparam logic [TIMEOUT_W-1:0] GAP_MAX = '1;
  logic [8:0] in_s;
  logic [7:0] data_s;
  logic valid_s;
`ifdef AES_INPORT_SYNC_EN
  aes_inport_sync #(.W(9), .RST_VAL(9'h100)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i ({in_valid, in_data}),
    .q_o (in_s)
  );
`else
  assign in_s = {in_valid, in_data};
`endif
  assign valid_s = in_s[8];
  assign data_s  = in_s[7:0];
  aes_state_e state_q, state_d;
  logic valid_q;
  logic [3:0] byte_cnt_q, byte_cnt_d;
  logic [1:0] word_cnt_q, word_cnt_d;
  logic [TIMEOUT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [BW-1:0] ibuf_q, ibuf_d, obuf_q, obuf_d;
  logic [AES_WORD_W-1:0] pass_data_q, pass_data_d;
  logic aes_en_q, aes_en_d, in_busy_q, in_busy_d, err_tout_q, err_tout_d;
  logic rise, done, expire;
  always_comb begin
    rise        = valid_s & ~valid_q;
    done        = rise && byte_cnt_q == 4'(AES_BLK_BYTES - 1);
    // A byte arriving on the expiry cycle is kept rather than discarded.
    expire      = !rise && byte_cnt_q != 4'd0 && gap_cnt_q == GAP_MAX;
    byte_cnt_d  = expire ? 4'd0 : rise ? byte_cnt_q + 4'd1 : byte_cnt_q;
    gap_cnt_d   = (rise || expire) ? '0
                : (byte_cnt_q != 4'd0 && gap_cnt_q != GAP_MAX) ? gap_cnt_q + 1'b1 : gap_cnt_q;
    ibuf_d      = ibuf_q;
    if (rise) ibuf_d[{~byte_cnt_q, 3'b000} +: 8] = data_s;
    obuf_d      = done ? {ibuf_q[BW-1:8], data_s} : obuf_q;
    state_d     = state_q == IDLE ? (done ? SEND : IDLE)
                : (word_cnt_q == 2'(AES_BLK_WORDS - 1) ? IDLE : SEND);
    word_cnt_d  = state_q == SEND ? word_cnt_q + 2'd1 : 2'd0;
    aes_en_d    = state_d == SEND;
    in_busy_d   = state_d == SEND;
    pass_data_d = aes_en_d ? aes_word(obuf_d, word_cnt_d) : pass_data_q;
    err_tout_d  = expire;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= 1'b1;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      ibuf_q      <= '0;
      obuf_q      <= '0;
      pass_data_q <= '0;
      aes_en_q    <= 1'b0;
      in_busy_q   <= 1'b0;
      err_tout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_s;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ibuf_q      <= ibuf_d;
      obuf_q      <= obuf_d;
      pass_data_q <= pass_data_d;
      aes_en_q    <= aes_en_d;
      in_busy_q   <= in_busy_d;
      err_tout_q  <= err_tout_d;
    end
  end
  assign pass_data = pass_data_q;
  assign aes_en    = aes_en_q;
  assign in_busy   = in_busy_q;
  assign err_tout  = err_tout_q;
endmodule

// File: tb/tb_aes_inport.sv
// tb_aes_inport: directed scoreboard bench for aes_inport (honours AES_INPORT_SYNC_EN latency).
module tb_aes_inport;
`ifdef AES_INPORT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b1;
  logic [31:0] pass_data;
  logic aes_en, in_busy, err_tout;
  int n_pass = 0, n_total = 0, en_cnt = 0, busy_cnt = 0, err_cnt = 0;
  logic [31:0] exp_q[$];
  always #5 clk = ~clk;
  aes_inport #(.TIMEOUT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .pass_data (pass_data),
    .aes_en    (aes_en),
    .in_busy   (in_busy),
    .err_tout  (err_tout)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask
  task automatic push_words(input logic [127:0] blk, input int n);
    for (int w = 0; w < n; w++) exp_q.push_back(blk[127-32*w -: 32]);
  endtask
  task automatic send_blk(input logic [127:0] blk, input int first, input int gap, input int n);
    for (int k = first; k < 16; k++) begin
      if (k == 15) push_words(blk, n);
      send_byte(blk[127-8*k -: 8], gap);
    end
  endtask
  task automatic wait_drain();
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
  endtask
  always @(negedge clk) begin
    if (err_tout) err_cnt++;
    if (in_busy) busy_cnt++;
    if (aes_en) begin
      en_cnt++;
      chk("busy_with_en", in_busy, 1);
      chk("en_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("burst_word", pass_data, exp_q.pop_front());
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic [127:0] blk;
    int i, e0;
    repeat (3) @(negedge clk);
    chk("rst_pass_data", pass_data, 0);
    chk("rst_aes_en", aes_en, 0);
    chk("rst_in_busy", in_busy, 0);
    chk("rst_err_tout", err_tout, 0);
    rst = 1'b0;
    // strobe held high across reset release must not count as a byte
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    blk = 128'hA5010203_04050607_08090A0B_0C0D0E0F;
    for (int k = 0; k < 15; k++) send_byte(blk[127-8*k -: 8], 8);
    chk("held_valid_no_en", en_cnt, 0);
    push_words(blk, 4);
    send_byte(blk[7:0], 8);
    wait_drain();
    blk = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    for (int k = 0; k < 15; k++) send_byte(blk[127-8*k -: 8], 8);
    push_words(blk, 4);
    @(negedge clk);
    in_data  = 8'h0F;
    in_valid = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("latency_pre", aes_en, 0);
    @(negedge clk);
    chk("latency_first_en", aes_en, 1);
    in_valid = 1'b0;
    wait_drain();
    e0 = err_cnt;
    for (int k = 0; k < 5; k++) send_byte(8'hE0 + 8'(k), 2);
    for (i = 0; i < 200 && !err_tout; i++) @(negedge clk);
    chk("tout_time", i, 64 + LAT);
    @(negedge clk);
    chk("tout_pulse_width", err_tout, 0);
    chk("tout_count", err_cnt, e0 + 1);
    blk = 128'h10111213_14151617_18191A1B_1C1D1E1F;
    send_blk(blk, 0, 2, 4);
    wait_drain();
    e0 = err_cnt;
    blk = 128'h20212223_24252627_28292A2B_2C2D2E2F;
    send_byte(blk[127:120], 2);
    repeat (62) @(negedge clk);
    send_blk(blk, 1, 2, 4);
    wait_drain();
    chk("rise_wins_no_tout", err_cnt, e0);
    busy_cnt = 0;
    send_blk(128'h40414243_44454647_48494A4B_4C4D4E4F, 0, 2, 4);
    send_blk(128'h50515253_54555657_58595A5B_5C5D5E5F, 0, 2, 4);
    wait_drain();
    repeat (4) @(negedge clk);
    chk("busy_cycles", busy_cnt, 8);
    blk = 128'h60616263_64656667_68696A6B_6C6D6E6F;
    send_blk(blk, 0, 2, 3);
    for (i = 0; i < 20 && !(aes_en && pass_data === blk[95:64]); i++) @(negedge clk);
    chk("found_word1", i < 20, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_aes_en", aes_en, 0);
    chk("midrst_in_busy", in_busy, 0);
    chk("midrst_pass_data", pass_data, 0);
    repeat (6) @(negedge clk);
    wait_drain();
    blk = 128'h70717273_74757677_78797A7B_7C7D7E7F;
    send_blk(blk, 0, 4, 4);
    wait_drain();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
